fifo_rd_unpacker: RTL and testbench

- Read-side consumer of the 128-bit dual-clock FIFO, in the FIFO read clock domain.
- Pops one word at a time and serialises it into PIX_W-bit pixels over a valid/ready stream into the convolution engine.
- Tracks word count per frame and flags the last pixel of each frame.

---
 rtl/fifo_rd_unpacker_pkg.sv | 26 ++
 rtl/fifo_rd_unpacker_pix_mux.sv | 40 ++++
 rtl/fifo_rd_unpacker.sv | 90 +++++++++
 tb/tb_fifo_rd_unpacker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_unpacker_pkg.sv
// ============================================================================
// Module : fifo_rd_unpacker_pkg
// Brief  : Shared defaults, state encoding and width helper for the unpacker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_rd_unpacker_pkg;

  localparam int DEF_DATA_W      = 128;
  localparam int DEF_PIX_W       = 8;
  localparam int DEF_FRAME_WORDS = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_unpacker_pix_mux.sv
// ============================================================================
// Module : fifo_rd_unpacker_pix_mux
// Brief  : Word-to-pixel select; UNPACK_MSB_FIRST_EN reverses pixel order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_unpacker_pix_mux
  import fifo_rd_unpacker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic [DATA_W-1:0]                     hold_i,
  input  logic [width_min1(DATA_W/PIX_W)-1:0]   idx_i,
  output logic [PIX_W-1:0]                      pix_o
);

  localparam int NPIX  = DATA_W / PIX_W;
  localparam int IDX_W = width_min1(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  logic [PIX_W-1:0] w_pix [NPIX];
  logic [IDX_W-1:0] w_sel;

  for (genvar g = 0; g < NPIX; g++) begin : g_pix
    assign w_pix[g] = hold_i[g*PIX_W +: PIX_W];
  end

`ifdef UNPACK_MSB_FIRST_EN
  assign w_sel = LAST_IDX - idx_i;
`else
  assign w_sel = idx_i;
`endif

  assign pix_o = w_pix[w_sel];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_unpacker.sv
// ============================================================================
// Module : fifo_rd_unpacker
// Brief  : Pops 128-bit FIFO words and streams them out as pixels with
//          word/frame last flags. Option macro: UNPACK_MSB_FIRST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_unpacker
  import fifo_rd_unpacker_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rempty,
  output logic              rinc,
  input  logic              flush,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              frame_last
);

  localparam int NPIX  = DATA_W / PIX_W;
  localparam int IDX_W = width_min1(NPIX);
  localparam int CNT_W = width_min1(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              w_accept;

  assign pix_valid  = (state_q == ST_ACTIVE);
  assign pix_last   = pix_valid && (idx_q == LAST_IDX);
  assign frame_last = pix_last && (cnt_q == LAST_WORD);
  assign w_accept   = pix_valid && pix_ready;

  // Reset gates the pop so the FIFO is never touched while rrst_n is low.
  assign rinc = rrst_n && !flush && !rempty &&
                ((state_q == ST_IDLE) || (w_accept && pix_last));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (w_accept && pix_last) begin
        cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + CNT_W'(1);
      end
      if (rinc) begin
        hold_q  <= rdata;
        idx_q   <= '0;
        state_q <= ST_ACTIVE;
      end else if (w_accept) begin
        if (pix_last) begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  fifo_rd_unpacker_pix_mux #(
    .DATA_W (DATA_W),
    .PIX_W  (PIX_W)
  ) u_pix_mux (
    .hold_i (hold_q),
    .idx_i  (idx_q),
    .pix_o  (pix_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_unpacker.sv
// ============================================================================
// Module : tb_fifo_rd_unpacker
// Brief  : Randomised and directed bench with a queue-based pixel model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_unpacker;

  localparam int DATA_W = 128;
  localparam int PIX_W  = 8;
  localparam int FW     = 16;
  localparam int NPIX   = DATA_W / PIX_W;

  logic              rclk = 1'b0;
  logic              rrst_n;
  logic [DATA_W-1:0] rdata;
  logic              rempty;
  logic              rinc;
  logic              flush;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  logic              frame_last;

  fifo_rd_unpacker #(
    .DATA_W      (DATA_W),
    .PIX_W       (PIX_W),
    .FRAME_WORDS (FW)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .flush      (flush),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .frame_last (frame_last)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [PIX_W-1:0] d;
    logic             last;
    logic             flast;
  } pix_t;

  logic [DATA_W-1:0] fifo_q[$];
  pix_t              exp_q[$];
  int                model_cnt;
  int                n_checks;
  int                n_errors;
  int                n_pops;
  int                n_flast;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix_of(input logic [DATA_W-1:0] w, input int i);
`ifdef UNPACK_MSB_FIRST_EN
    return w[(NPIX-1-i)*PIX_W +: PIX_W];
`else
    return w[i*PIX_W +: PIX_W];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : rnd_word();
  endtask

  // One clock: called at the falling edge, returns at the next falling edge.
  task automatic step(input bit rdy, input bit fl);
    bit exp_valid, acc, exp_rinc;
    logic [DATA_W-1:0] w;
    pix_ready = rdy;
    flush     = fl;
    drive_fifo();
    #1;
    exp_valid = (exp_q.size() != 0);
    check("pix_valid", {31'd0, pix_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("pix_data",   {24'd0, pix_data},   {24'd0, exp_q[0].d});
      check("pix_last",   {31'd0, pix_last},   {31'd0, exp_q[0].last});
      check("frame_last", {31'd0, frame_last}, {31'd0, exp_q[0].flast});
    end
    acc      = exp_valid && rdy;
    exp_rinc = !fl && (fifo_q.size() != 0) && (!exp_valid || (acc && exp_q[0].last));
    check("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
    if (rinc) n_pops++;
    if (acc && exp_q[0].flast) n_flast++;
    @(posedge rclk);
    if (fl) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (acc) void'(exp_q.pop_front());
      if (exp_rinc) begin
        w = fifo_q.pop_front();
        for (int i = 0; i < NPIX; i++)
          exp_q.push_back('{d: pix_of(w, i), last: (i == NPIX-1),
                            flast: (i == NPIX-1) && (model_cnt == FW-1)});
        model_cnt = (model_cnt + 1) % FW;
      end
    end
    @(negedge rclk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, pix_valid},  32'd0);
    check({tag, "_last"},  {31'd0, pix_last},   32'd0);
    check({tag, "_flast"}, {31'd0, frame_last}, 32'd0);
    check({tag, "_data"},  {24'd0, pix_data},   32'd0);
    check({tag, "_rinc"},  {31'd0, rinc},       32'd0);
  endtask

  logic [DATA_W-1:0] ramp;

  initial begin
    n_checks = 0; n_errors = 0; n_pops = 0; n_flast = 0; model_cnt = 0;
    ramp = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    rrst_n = 1'b0; flush = 1'b0; pix_ready = 1'b1;
    fifo_q.push_back(ramp);
    drive_fifo();
    #2;
    check_idle_outputs("reset");
    repeat (3) begin
      @(posedge rclk); #1;
      check("reset_rinc", {31'd0, rinc}, 32'd0);
    end
    @(negedge rclk);
    rrst_n = 1'b1;

    // 1: single ramp word, LSB-first pixels, one pop.
    n_pops = 0;
    repeat (20) step(1'b1, 1'b0);
    check("t1_pops", n_pops, 32'd1);

    // 2: two words back to back with no bubble.
    n_pops = 0;
    fifo_q.push_back(ramp);
    fifo_q.push_back(rnd_word());
    repeat (36) step(1'b1, 1'b0);
    check("t2_pops", n_pops, 32'd2);

    // 3: stall on pixel 3 with another word waiting.
    fifo_q.push_back(ramp);
    fifo_q.push_back(rnd_word());
    repeat (4) step(1'b1, 1'b0);
    check("t3_at3", {24'd0, pix_data}, 32'h03);
    repeat (5) step(1'b0, 1'b0);
    check("t3_hold", {24'd0, pix_data}, 32'h03);
    repeat (36) step(1'b1, 1'b0);

    // 4: 17 words after a flush: frame_last exactly once.
    step(1'b1, 1'b1);
    n_flast = 0;
    for (int i = 0; i < 17; i++) fifo_q.push_back(rnd_word());
    repeat (17*NPIX + 4) step(1'b1, 1'b0);
    check("t4_flast", n_flast, 32'd1);

    // 5: flush at pixel 7 with FIFO non-empty.
    for (int i = 0; i < 3; i++) fifo_q.push_back(rnd_word());
    repeat (8) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("t5_valid", {31'd0, pix_valid}, 32'd0);
    repeat (40) step(1'b1, 1'b0);

    // 6: asynchronous reset at pixel 9.
    for (int i = 0; i < 3; i++) fifo_q.push_back(rnd_word());
    repeat (10) step(1'b1, 1'b0);
    check("t6_at9", {31'd0, pix_valid}, 32'd1);
    #2 rrst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    exp_q.delete();
    model_cnt = 0;
    repeat (2) begin
      @(posedge rclk); #1;
      check("t6_rst_rinc", {31'd0, rinc}, 32'd0);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (40) step(1'b1, 1'b0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) fifo_q.push_back(rnd_word());
      step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
